// File: rtl/fp32_max_tracker.sv
// Streaming fp32 frame max tracker: reports largest ordered operand, its beat index and special/empty flags per frame.
// Optional min tracking (min_32/min_index) is enabled by defining FP32_MIN_TRACK_EN.
module fp32_max_tracker (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] max_32,
   output logic [15:0] max_index,
   output logic        special_seen,
   output logic        none_valid
`ifdef FP32_MIN_TRACK_EN
   ,
   output logic [31:0] min_32,
   output logic [15:0] min_index
`endif
);

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 16;

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   // Monotonic unsigned key: negatives below zero below positives; exponent-0 operands collapse to zero.
   function automatic logic [DW-1:0] order_key(input logic [DW-1:0] v);
      if (v[30:23] == 8'd0)  order_key = 32'h8000_0000;
      else if (v[31])        order_key = {1'b0, ~v[30:0]};
      else                   order_key = {1'b1, v[30:0]};
   endfunction

   state_t          state_q, state_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   run_max_q, run_max_d;
   logic [IW-1:0]   run_max_idx_q, run_max_idx_d;
   logic            run_any_q, run_any_d;
   logic            run_spec_q, run_spec_d;
   logic [DW-1:0]   max_32_q, max_32_d;
   logic [IW-1:0]   max_index_q, max_index_d;
   logic            special_q, special_d;
   logic            none_q, none_d;
   logic            xfer, is_spec, take_max, nany, nspec;
   logic [DW-1:0]   cand_key, nmax;
   logic [IW-1:0]   nmax_idx;
`ifdef FP32_MIN_TRACK_EN
   logic [DW-1:0]   run_min_q, run_min_d, min_32_q, min_32_d, nmin;
   logic [IW-1:0]   run_min_idx_q, run_min_idx_d, min_index_q, min_index_d, nmin_idx;
   logic            take_min;
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      run_max_d     = run_max_q;
      run_max_idx_d = run_max_idx_q;
      run_any_d     = run_any_q;
      run_spec_d    = run_spec_q;
      max_32_d      = max_32_q;
      max_index_d   = max_index_q;
      special_d     = special_q;
      none_d        = none_q;

      xfer     = in_valid && in_ready_q;
      is_spec  = (in_data[30:23] == 8'hFF);
      cand_key = order_key(in_data);
      take_max = !is_spec && (!run_any_q || (cand_key > order_key(run_max_q)));
      nmax     = take_max ? in_data : run_max_q;
      nmax_idx = take_max ? cnt_q : run_max_idx_q;
      nany     = run_any_q || !is_spec;
      nspec    = run_spec_q || is_spec;
`ifdef FP32_MIN_TRACK_EN
      run_min_d     = run_min_q;
      run_min_idx_d = run_min_idx_q;
      min_32_d      = min_32_q;
      min_index_d   = min_index_q;
      take_min      = !is_spec && (!run_any_q || (cand_key < order_key(run_min_q)));
      nmin          = take_min ? in_data : run_min_q;
      nmin_idx      = take_min ? cnt_q : run_min_idx_q;
`endif

      unique case (state_q)
         IDLE, ACCUM: if (xfer) state_d = in_last ? HOLD : ACCUM;
         HOLD:        if (out_valid_q && out_ready) state_d = IDLE;
         default:     state_d = IDLE;
      endcase

      // Final beat publishes the frame result and clears the running state for the next frame.
      if (xfer) begin
         if (in_last) begin
            max_32_d      = nany ? nmax : '0;
            max_index_d   = nany ? nmax_idx : '0;
            special_d     = nspec;
            none_d        = !nany;
            run_max_d     = '0;
            run_max_idx_d = '0;
            run_any_d     = 1'b0;
            run_spec_d    = 1'b0;
            cnt_d         = '0;
`ifdef FP32_MIN_TRACK_EN
            min_32_d      = nany ? nmin : '0;
            min_index_d   = nany ? nmin_idx : '0;
            run_min_d     = '0;
            run_min_idx_d = '0;
`endif
         end else begin
            run_max_d     = nmax;
            run_max_idx_d = nmax_idx;
            run_any_d     = nany;
            run_spec_d    = nspec;
            cnt_d         = (cnt_q == {IW{1'b1}}) ? cnt_q : cnt_q + IW'(1);
`ifdef FP32_MIN_TRACK_EN
            run_min_d     = nmin;
            run_min_idx_d = nmin_idx;
`endif
         end
      end

      in_ready_d  = (state_d != HOLD);
      out_valid_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         cnt_q         <= '0;
         run_max_q     <= '0;
         run_max_idx_q <= '0;
         run_any_q     <= 1'b0;
         run_spec_q    <= 1'b0;
         max_32_q      <= '0;
         max_index_q   <= '0;
         special_q     <= 1'b0;
         none_q        <= 1'b0;
`ifdef FP32_MIN_TRACK_EN
         run_min_q     <= '0;
         run_min_idx_q <= '0;
         min_32_q      <= '0;
         min_index_q   <= '0;
`endif
      end else begin
         state_q       <= state_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         cnt_q         <= cnt_d;
         run_max_q     <= run_max_d;
         run_max_idx_q <= run_max_idx_d;
         run_any_q     <= run_any_d;
         run_spec_q    <= run_spec_d;
         max_32_q      <= max_32_d;
         max_index_q   <= max_index_d;
         special_q     <= special_d;
         none_q        <= none_d;
`ifdef FP32_MIN_TRACK_EN
         run_min_q     <= run_min_d;
         run_min_idx_q <= run_min_idx_d;
         min_32_q      <= min_32_d;
         min_index_q   <= min_index_d;
`endif
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign max_32       = max_32_q;
   assign max_index    = max_index_q;
   assign special_seen = special_q;
   assign none_valid   = none_q;
`ifdef FP32_MIN_TRACK_EN
   assign min_32       = min_32_q;
   assign min_index    = min_index_q;
`endif

endmodule
